// File: rtl/dale_frame_controller.sv
// Frame-level sequencer for DALE: accumulates the dark channel per frame and decides
// whether the next frame runs with a global atmosphere-light refresh or in local mode.
module dale_frame_controller #(
  parameter int IMG_W          = 640,
  parameter int IMG_H          = 480,
  parameter int REFRESH_FRAMES = 30,
  parameter int SC_THRESH      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sof,
  input  logic       pix_valid,
  output logic       in_ready,
  input  logic [7:0] i_dark,
  output logic       dale_en,
  output logic       gbl_capture,
  output logic       scene_change,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int N     = IMG_W * IMG_H;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SUM_W = 8 + $clog2(N);
  localparam int FC_W  = $clog2(REFRESH_FRAMES + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [SUM_W-1:0] THRESH   = SUM_W'(SC_THRESH * N);
  localparam logic [FC_W-1:0]  RF_LAST  = FC_W'(REFRESH_FRAMES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EVAL = 2'd2, UPDATE = 2'd3} state_t;

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] pix_cnt_r;
  logic [SUM_W-1:0] sum_r, prev_sum_r, diff_s;
  logic [FC_W-1:0]  frame_ctr_r;
  logic             first_frame_r, req_r, sc_r;
  logic             in_ready_r, dale_en_r, gbl_capture_r, scene_change_r, frame_done_r, frame_err_r;
  logic             accept_s, start_s, add_s, err_s, sc_s, rf_s;

  assign accept_s = pix_valid & in_ready_r;
  assign diff_s   = (sum_r >= prev_sum_r) ? (sum_r - prev_sum_r) : (prev_sum_r - sum_r);
  assign sc_s     = (diff_s > THRESH);
  assign rf_s     = (frame_ctr_r == RF_LAST);

  // Next-state decode and per-pixel datapath controls
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    add_s        = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && sof) begin
          start_s      = 1'b1;
          next_state_s = (N == 1) ? EVAL : RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && sof) begin
          // restart: the partial frame is dropped without a decision
          start_s      = 1'b1;
          err_s        = 1'b1;
          next_state_s = (N == 1) ? EVAL : RUN;
        end else if (accept_s) begin
          add_s        = 1'b1;
          next_state_s = (pix_cnt_r == LAST_CNT) ? EVAL : RUN;
        end else begin
          next_state_s = RUN;
        end
      end
      EVAL:    next_state_s = UPDATE;
      UPDATE:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, accumulators and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      pix_cnt_r      <= '0;
      sum_r          <= '0;
      prev_sum_r     <= '0;
      frame_ctr_r    <= '0;
      first_frame_r  <= 1'b1;
      req_r          <= 1'b0;
      sc_r           <= 1'b0;
      in_ready_r     <= 1'b1;
      dale_en_r      <= 1'b1;
      gbl_capture_r  <= 1'b0;
      scene_change_r <= 1'b0;
      frame_done_r   <= 1'b0;
      frame_err_r    <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      in_ready_r    <= (next_state_s == IDLE) || (next_state_s == RUN);
      frame_err_r   <= err_s;
      gbl_capture_r <= 1'b0;
      frame_done_r  <= 1'b0;
      if (start_s) begin
        pix_cnt_r <= CNT_W'(1);
        sum_r     <= SUM_W'(i_dark);
      end else if (add_s) begin
        pix_cnt_r <= pix_cnt_r + CNT_W'(1);
        sum_r     <= sum_r + SUM_W'(i_dark);
      end
      if (state_r == EVAL) begin
        req_r <= first_frame_r | sc_s | rf_s;
        sc_r  <= sc_s;
      end
      if (state_r == UPDATE) begin
        dale_en_r      <= req_r;
        gbl_capture_r  <= req_r;
        frame_done_r   <= 1'b1;
        scene_change_r <= sc_r & ~first_frame_r;
        prev_sum_r     <= sum_r;
        frame_ctr_r    <= req_r ? '0 : (frame_ctr_r + FC_W'(1));
        first_frame_r  <= 1'b0;
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign dale_en      = dale_en_r;
  assign gbl_capture  = gbl_capture_r;
  assign scene_change = scene_change_r;
  assign frame_done   = frame_done_r;
  assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_dale_frame_controller.sv
// Bench for dale_frame_controller: table of whole frames with a decision scoreboard,
// plus hand-written reset, idle-junk, mid-frame sof and mid-frame reset sequences.
module tb_dale_frame_controller;

  logic       clk = 1'b0;
  logic       rst, sof, pix_valid;
  logic [7:0] i_dark;
  logic       in_ready, dale_en, gbl_capture, scene_change, frame_done, frame_err;

  dale_frame_controller #(.IMG_W(4), .IMG_H(2), .REFRESH_FRAMES(3), .SC_THRESH(16)) dut (
    .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .in_ready(in_ready),
    .i_dark(i_dark), .dale_en(dale_en), .gbl_capture(gbl_capture),
    .scene_change(scene_change), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] val;
    logic       dale;
    logic       gbl;
    logic       sc;
  } vec_t;

  typedef struct {
    logic dale;
    logic gbl;
    logic sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, done_cnt = 0, err_cnt = 0;
  logic prev_done = 1'b0, prev_err = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Decision scoreboard and strobe-width monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("dale_en", {31'd0, dale_en}, {31'd0, e.dale});
          check("gbl_capture", {31'd0, gbl_capture}, {31'd0, e.gbl});
          check("scene_change", {31'd0, scene_change}, {31'd0, e.sc});
        end
      end
      if (prev_done) check("done_width", {31'd0, frame_done | gbl_capture}, 32'd0);
      if (frame_err) err_cnt++;
      if (prev_err) check("err_width", {31'd0, frame_err}, 32'd0);
      prev_done <= frame_done;
      prev_err  <= frame_err;
    end else begin
      prev_done <= 1'b0;
      prev_err  <= 1'b0;
    end
  end

  task automatic drive_pix(input logic s, input logic [7:0] v);
    int waits;
    pix_valid = 1'b1;
    sof       = s;
    i_dark    = v;
    waits     = 0;
    while (!in_ready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 20) check("ready_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] v, input logic ed, input logic eg, input logic es);
    exp_t e;
    for (int p = 0; p < 8; p++) begin
      if (p == 7) begin
        e.dale = ed; e.gbl = eg; e.sc = es;
        exp_q.push_back(e);
      end
      drive_pix(p == 0, v);
    end
    @(negedge clk); check("rdy_eval", {31'd0, in_ready}, 32'd0);
    @(negedge clk); check("rdy_update", {31'd0, in_ready}, 32'd0);
    @(negedge clk); check("rdy_back", {31'd0, in_ready}, 32'd1);
    @(negedge clk); check("decision_seen", exp_q.size(), 32'd0);
  endtask

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'd50, 1'b1, 1'b1, 1'b0};  // first frame
    tbl[1] = '{8'd52, 1'b0, 1'b0, 1'b0};  // diff 16
    tbl[2] = '{8'd52, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'd52, 1'b1, 1'b1, 1'b0};  // periodic refresh
    tbl[4] = '{8'd50, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'd67, 1'b1, 1'b1, 1'b1};  // diff 136
    tbl[6] = '{8'd50, 1'b1, 1'b1, 1'b1};  // diff 136 downward
    tbl[7] = '{8'd66, 1'b0, 1'b0, 1'b0};  // diff exactly 128
    tbl[8] = '{8'd66, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{8'd0,  1'b1, 1'b1, 1'b1};  // scene change and refresh together

    rst = 1'b1; sof = 1'b0; pix_valid = 1'b0; i_dark = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_dale_en", {31'd0, dale_en}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_strobes", {28'd0, gbl_capture, scene_change, frame_done, frame_err}, 32'd0);

    // pixels without sof in IDLE must be ignored
    @(posedge clk); #1;
    pix_valid = 1'b1; i_dark = 8'd99;
    repeat (5) @(posedge clk);
    #1 pix_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("idle_no_done", done_cnt, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_frame(tbl[i].val, tbl[i].dale, tbl[i].gbl, tbl[i].sc);
    end

    // sof at pixel 5: partial frame of 200s must not reach the sum
    for (int p = 0; p < 4; p++) drive_pix(p == 0, 8'd200);
    run_frame(8'd10, 1'b0, 1'b0, 1'b0);
    check("frame_err_count", err_cnt, 32'd1);

    // reset at pixel 3: next frame behaves as the first regardless of i_dark
    check("pre_rst_dale_en", {31'd0, dale_en}, 32'd0);
    drive_pix(1'b1, 8'd77);
    drive_pix(1'b0, 8'd77);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_dale_en", {31'd0, dale_en}, 32'd1);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    run_frame(8'd255, 1'b1, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("total_done", done_cnt, 32'd12);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
